// File: rtl/demux2_stream_pkg.sv
// demux2_stream_pkg: shared widths and select encodings for the 1:2 stream demux
package demux2_stream_pkg;
  localparam int DMX_N = 32;
  localparam int DMX_CW = 16;
  localparam logic SEL_OUT0 = 1'b0;
  localparam logic SEL_OUT1 = 1'b1;
endpackage

// File: rtl/demux2_stream_fifo2.sv
// demux2_stream_fifo2: 2-entry registered FIFO with head output and no push/pop bypass
module demux2_stream_fifo2 #(
  parameter int n = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [n-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [n-1:0] head
);
  logic [1:0]   cnt;
  logic [n-1:0] mem1;
  logic         do_push;
  logic         do_pop;
  assign full    = cnt == 2'd2;
  assign empty   = cnt == 2'd0;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  // Head is slot 0; a pop shifts slot 1 forward, an emptying pop leaves head unchanged
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= 2'd0;
      head <= '0;
      mem1 <= '0;
    end else begin
      if (do_push && (empty || (cnt == 2'd1 && do_pop))) head <= din;
      else if (do_pop && full) head <= mem1;
      if (do_push && cnt == 2'd1 && !do_pop) mem1 <= din;
      cnt <= cnt + {1'b0, do_push} - {1'b0, do_pop};
    end
  end
endmodule

// File: rtl/demux2_stream.sv
// demux2_stream: steers one valid/ready stream to one of two buffered outputs with pop counters
module demux2_stream
  import demux2_stream_pkg::*;
#(
  parameter int n  = DMX_N,
  parameter int CW = DMX_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [n-1:0]  in_data,
  input  logic          in_sel,
  output logic          out0_valid,
  input  logic          out0_ready,
  output logic [n-1:0]  out0_data,
  output logic          out1_valid,
  input  logic          out1_ready,
  output logic [n-1:0]  out1_data,
  output logic [CW-1:0] cnt0,
  output logic [CW-1:0] cnt1
);
  logic full0, full1, empty0, empty1;
  logic push0, push1, pop0, pop1;
  assign in_ready   = ~rst & (in_sel == SEL_OUT1 ? ~full1 : ~full0);
  assign push0      = in_valid & in_ready & (in_sel == SEL_OUT0);
  assign push1      = in_valid & in_ready & (in_sel == SEL_OUT1);
  assign out0_valid = ~empty0;
  assign out1_valid = ~empty1;
  assign pop0       = out0_valid & out0_ready;
  assign pop1       = out1_valid & out1_ready;
  demux2_stream_fifo2 #(.n(n)) u_fifo0 (
    .clk(clk), .rst(rst), .push(push0), .pop(pop0), .din(in_data),
    .full(full0), .empty(empty0), .head(out0_data)
  );
  demux2_stream_fifo2 #(.n(n)) u_fifo1 (
    .clk(clk), .rst(rst), .push(push1), .pop(pop1), .din(in_data),
    .full(full1), .empty(empty1), .head(out1_data)
  );
  // Delivered-word counters, wrapping silently
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      cnt0 <= cnt0 + CW'(pop0);
      cnt1 <= cnt1 + CW'(pop1);
    end
  end
endmodule
